// File: rtl/crc_chk_param.sv
// crc_chk_param: serial CRC checker; ports clk/g_rst, frm_start, bit_vld/bit_in/data_last stream, clear events in, crc_reg/rcvd_crc/chk_done/crc_err out
module crc_chk_param #(
  parameter int CRC_W = 13,
  parameter logic [CRC_W-1:0] POLY = 13'h1B5F,
  parameter logic [CRC_W-1:0] INIT = '0,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             g_rst,
  input  logic             frm_start,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             data_last,
  input  logic             rx_success,
  input  logic             act_err_frm_tx,
  input  logic             psv_err_frm_tx,
  output logic [CRC_W-1:0] crc_reg,
  output logic [CRC_W-1:0] rcvd_crc,
  output logic             chk_done,
  output logic             crc_err
);
  localparam int CW = $clog2(CRC_W);
  localparam logic [CW-1:0] LAST = CW'(CRC_W - 1);
  typedef enum logic [1:0] {IDLE, CALC, RCV, DONE} state_t;
  state_t state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d, rcvd_q, rcvd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done_q, done_d, err_q, err_d;
  logic clr, fb;
  assign clr = rx_success | act_err_frm_tx | psv_err_frm_tx;
  assign fb = bit_in ^ crc_q[CRC_W-1];
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    rcvd_d = rcvd_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    err_d = ERR_STICKY ? err_q : 1'b0;
    if (clr) begin
      state_d = IDLE;
      crc_d = INIT;
      rcvd_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (frm_start) begin
      state_d = CALC;
      crc_d = INIT;
      rcvd_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (bit_vld && state_q == CALC) begin
      crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
      state_d = data_last ? RCV : CALC;
    end else if (bit_vld && state_q == RCV) begin
      rcvd_d = {rcvd_q[CRC_W-2:0], bit_in};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        done_d = 1'b1;
        err_d = crc_q != rcvd_d;
        cnt_d = '0;
        state_d = DONE;
      end
    end
  end
  always_ff @(posedge clk or posedge g_rst)
    if (g_rst) begin
      state_q <= IDLE;
      crc_q <= INIT;
      rcvd_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      rcvd_q <= rcvd_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign crc_reg = crc_q;
  assign rcvd_crc = rcvd_q;
  assign chk_done = done_q;
  assign crc_err = err_q;
endmodule

// File: tb/tb_crc_chk_param.sv
// tb_crc_chk_param: random and directed checks of crc_chk_param against a polynomial-division reference
module tb_crc_chk_param;
  logic clk = 1'b0, g_rst = 1'b1, frm_start = 1'b0, bit_vld = 1'b0, bit_in = 1'b0, data_last = 1'b0;
  logic rx_success = 1'b0, act_err_frm_tx = 1'b0, psv_err_frm_tx = 1'b0;
  logic [2:0] crc3s, rcvd3s, crc3p, rcvd3p;
  logic [12:0] crc13, rcvd13;
  logic done3s, err3s, done3p, err3p, done13, err13;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  crc_chk_param #(.CRC_W(3), .POLY(3'b011), .INIT(3'b000), .ERR_STICKY(1'b1)) u3s (
    .clk(clk), .g_rst(g_rst), .frm_start(frm_start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_last(data_last), .rx_success(rx_success), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .crc_reg(crc3s), .rcvd_crc(rcvd3s), .chk_done(done3s), .crc_err(err3s));
  crc_chk_param #(.CRC_W(3), .POLY(3'b011), .INIT(3'b000), .ERR_STICKY(1'b0)) u3p (
    .clk(clk), .g_rst(g_rst), .frm_start(frm_start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_last(data_last), .rx_success(rx_success), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .crc_reg(crc3p), .rcvd_crc(rcvd3p), .chk_done(done3p), .crc_err(err3p));
  crc_chk_param u13 (
    .clk(clk), .g_rst(g_rst), .frm_start(frm_start), .bit_vld(bit_vld), .bit_in(bit_in),
    .data_last(data_last), .rx_success(rx_success), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .crc_reg(crc13), .rcvd_crc(rcvd13), .chk_done(done13), .crc_err(err13));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input logic last, input int gap);
    bit_vld = 1'b1;
    bit_in = b;
    data_last = last;
    tick;
    bit_vld = 1'b0;
    data_last = 1'b0;
    repeat (gap) tick;
  endtask
  function automatic logic [31:0] ref_crc(input int w, input longint unsigned poly, input int n, input longint unsigned d);
    longint unsigned m, g;
    m = d << w;
    g = (64'd1 << w) | poly;
    for (int i = n + w - 1; i >= w; i--)
      if (m[i]) m = m ^ (g << (i - w));
    return 32'(m & ((64'd1 << w) - 1));
  endfunction
  function automatic logic [31:0] g_crc(input int w);
    return w == 3 ? 32'(crc3s) : 32'(crc13);
  endfunction
  function automatic logic [31:0] g_rcvd(input int w);
    return w == 3 ? 32'(rcvd3s) : 32'(rcvd13);
  endfunction
  function automatic logic [31:0] g_done(input int w);
    return w == 3 ? 32'(done3s) : 32'(done13);
  endfunction
  function automatic logic [31:0] g_err(input int w);
    return w == 3 ? 32'(err3s) : 32'(err13);
  endfunction
  task automatic start;
    frm_start = 1'b1;
    bit_vld = 1'b1;
    bit_in = 1'b1;
    tick;
    frm_start = 1'b0;
    bit_vld = 1'b0;
  endtask
  task automatic frame(input int w, input int n, input longint unsigned d, input longint unsigned f, input int gmax);
    logic [31:0] r;
    bit bad;
    r = ref_crc(w, w == 3 ? 64'h3 : 64'h1B5F, n, d);
    bad = 32'(f) != r;
    start;
    for (int i = n - 1; i >= 0; i--) send(d[i], i == 0, $urandom_range(0, gmax));
    chk("crc_after_data", g_crc(w), r);
    for (int i = w - 1; i >= 0; i--) send(f[i], 1'b0, i == 0 ? 0 : $urandom_range(0, gmax));
    chk("chk_done", g_done(w), 1);
    chk("crc_err", g_err(w), 32'(bad));
    chk("rcvd_crc", g_rcvd(w), 32'(f));
    chk("crc_frozen", g_crc(w), r);
    if (w == 3) begin
      chk("pulsed_done", 32'(done3p), 1);
      chk("pulsed_err", 32'(err3p), 32'(bad));
    end
    tick;
    chk("done_one_cycle", g_done(w), 0);
    chk("err_after_done", g_err(w), 32'(bad));
    if (w == 3) chk("pulsed_err_clear", 32'(err3p), 0);
  endtask
  initial begin
    longint unsigned d, f;
    int n;
    tick;
    chk("rst_crc3", 32'(crc3s), 0);
    chk("rst_rcvd3", 32'(rcvd3s), 0);
    chk("rst_done3", 32'(done3s), 0);
    chk("rst_err3", 32'(err3s), 0);
    chk("rst_crc13", 32'(crc13), 0);
    chk("rst_done13", 32'(done13), 0);
    g_rst = 1'b0;
    tick;
    frame(3, 3, 64'b101, 64'b100, 0);
    chk("match_crc_100", 32'(crc3s), 32'b100);
    frame(3, 3, 64'b101, 64'b101, 0);
    repeat (10) tick;
    chk("sticky_held", 32'(err3s), 1);
    chk("pulsed_stays_low", 32'(err3p), 0);
    rx_success = 1'b1;
    tick;
    rx_success = 1'b0;
    chk("sticky_cleared", 32'(err3s), 0);
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 20);
      d = {32'($urandom), 32'($urandom)} & ((64'd1 << n) - 1);
      f = 64'(ref_crc(3, 64'h3, n, d)) ^ (($urandom_range(0, 1) == 1) ? (64'd1 << $urandom_range(0, 2)) : 64'd0);
      frame(3, n, d, f, 5);
    end
    start;
    send(1'b1, 1'b0, 2);
    send(1'b0, 1'b0, 0);
    send(1'b1, 1'b1, 3);
    send(1'b1, 1'b0, 1);
    send(1'b0, 1'b0, 0);
    act_err_frm_tx = 1'b1;
    send(1'b1, 1'b0, 0);
    act_err_frm_tx = 1'b0;
    chk("abort_done", 32'(done3s), 0);
    chk("abort_err", 32'(err3s), 0);
    chk("abort_rcvd", 32'(rcvd3s), 0);
    for (int i = 0; i < 3; i++) send(1'b1, i == 2, 0);
    chk("idle_crc_hold", 32'(crc3s), 0);
    chk("idle_no_done", 32'(done3s), 0);
    start;
    send(1'b1, 1'b0, 0);
    send(1'b1, 1'b1, 0);
    send(1'b1, 1'b0, 0);
    frm_start = 1'b1;
    tick;
    frm_start = 1'b0;
    chk("restart_crc", 32'(crc3s), 0);
    chk("restart_rcvd", 32'(rcvd3s), 0);
    frame(3, 5, 64'b11010, 64'(ref_crc(3, 64'h3, 5, 64'b11010)), 2);
    start;
    send(1'b1, 1'b0, 0);
    send(1'b1, 1'b0, 0);
    #2 g_rst = 1'b1;
    #1;
    chk("async_rst_crc", 32'(crc3s), 0);
    chk("async_rst_crc13", 32'(crc13), 0);
    g_rst = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) send(1'b1, i == 2, 0);
    chk("post_rst_crc", 32'(crc3s), 0);
    chk("post_rst_rcvd", 32'(rcvd3s), 0);
    chk("post_rst_done", 32'(done3s), 0);
    for (int k = 0; k < 64; k++) begin
      n = $urandom_range(1, 40);
      d = {32'($urandom), 32'($urandom)} & ((64'd1 << n) - 1);
      frame(13, n, d, 64'(ref_crc(13, 64'h1B5F, n, d)), $urandom_range(0, 2));
    end
    d = 64'hA5C3_1F;
    frame(13, 24, d, 64'(ref_crc(13, 64'h1B5F, 24, d)) ^ (64'd1 << $urandom_range(0, 12)), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/crc_chk_param.md
# crc_chk_param

Parametrised serial CRC checker for the CAN XL receive path. It computes a CRC over the destuffed bit stream of a frame section, then captures the transmitted CRC field serially and compares the two. It raises a checker-done pulse and an error flag that the error-handling logic samples. It generalises the fixed 13-bit preface-CRC comparator: it adds configurable width, polynomial and initial value, on-the-fly CRC computation, serial field capture, and a selectable sticky or pulsed error mode.

## Interface

Parameters:
- CRC_W, 13: CRC width in bits; legal range 3..32.
- POLY, 13'h1B5F: generator polynomial, implicit top bit omitted, CRC_W bits.
- INIT, 0: CRC register value loaded at frame start, CRC_W bits.
- ERR_STICKY, 1: 1 = crc_err holds until a clear event; 0 = crc_err is a one-cycle pulse coincident with chk_done.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- g_rst, input, 1: asynchronous, active-high reset.
- frm_start, input, 1: one-cycle pulse; (re)starts a check.
- bit_vld, input, 1: qualifies bit_in; one destuffed bit per asserted cycle.
- bit_in, input, 1: received destuffed bit.
- data_last, input, 1: asserted together with bit_vld on the final CRC-covered bit.
- rx_success, input, 1: frame received OK; clear event.
- act_err_frm_tx, input, 1: active error frame being sent; clear event.
- psv_err_frm_tx, input, 1: passive error frame being sent; clear event.
- crc_reg, output, CRC_W: running computed CRC.
- rcvd_crc, output, CRC_W: captured CRC field, MSB first.
- chk_done, output, 1: one-cycle pulse when the comparison is made.
- crc_err, output, 1: mismatch flag.

## Operation

- States: IDLE, CALC, RCV, DONE. A CRC_W-sized bit counter cnt, wide enough for CRC_W-1, is used only in RCV.
- Priority per cycle, highest first: g_rst, then clear event (rx_success | act_err_frm_tx | psv_err_frm_tx), then frm_start, then the normal state action.
- Clear event, from any state:
  - go to IDLE;
  - crc_err=0, chk_done=0;
  - crc_reg=INIT, rcvd_crc=0, cnt=0.
- frm_start, from any state:
  - go to CALC;
  - crc_reg=INIT, rcvd_crc=0, cnt=0;
  - crc_err=0;
  - a bit_vld in the same cycle is ignored.
- CALC, each bit_vld cycle:
  - fb = bit_in ^ crc_reg[CRC_W-1];
  - crc_reg = {crc_reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - If data_last is also high, the update still applies, then go to RCV.
- RCV, each bit_vld cycle:
  - rcvd_crc = {rcvd_crc[CRC_W-2:0], bit_in}, cnt++.
  - On the bit where cnt==CRC_W-1:
    - chk_done=1 next cycle;
    - crc_err = (crc_reg != {rcvd_crc[CRC_W-2:0],bit_in});
    - cnt=0; go to DONE.
  - crc_reg is frozen in RCV.
- DONE:
  - bit_vld and data_last are ignored.
  - If ERR_STICKY=1, crc_err holds until a clear event or frm_start.
  - If ERR_STICKY=0, crc_err is cleared the cycle after chk_done.
- IDLE: bit_vld and data_last are ignored; all registers hold.
- data_last outside CALC is ignored. bit_vld low means no state or register change.

## Timing

- Reset values: state=IDLE, crc_reg=INIT, rcvd_crc=0, cnt=0, chk_done=0, crc_err=0.
- All outputs are registered.
- crc_reg reflects a bit one clock after its bit_vld cycle.
- chk_done and crc_err are valid one clock after the cycle sampling the last CRC field bit.
- chk_done is exactly one cycle wide.
- bit_vld may be asserted on consecutive cycles or with arbitrary gaps; gaps do not affect the result.
- Clear event in the same cycle as the final RCV bit: the clear wins, so no chk_done and crc_err=0.
- Reset asserted mid-frame: all registers return to reset values immediately and asynchronously.

## Test plan

- Match. Setup: CRC_W=3, POLY=3'b011, INIT=0, ERR_STICKY=1. Stimulus: frm_start, then data bits 1,0,1 (data_last on the 3rd), then field bits 1,0,0. Required: crc_reg=3'b100 after the data bits; chk_done one cycle; crc_err=0; rcvd_crc=3'b100.
- Mismatch, sticky. Same setup and data bits, field bits 1,0,1. Required: chk_done pulse; crc_err=1 held for 10+ cycles, cleared the cycle after rx_success.
- Pulsed mode. Same mismatch stimulus with ERR_STICKY=0. Required: crc_err=1 only in the chk_done cycle.
- Gapped bits and abort. Insert idle gaps of 0–5 cycles between bits. Required: identical results to the ungapped runs. Then assert act_err_frm_tx together with the last RCV bit. Required: no chk_done, crc_err=0, state IDLE.
- Restart and reset. frm_start mid-RCV. Required: crc_reg=INIT and a fresh check completes correctly. Then assert g_rst mid-CALC. Required: all outputs at reset values, ignoring bits until the next frm_start.
- Default config. CRC_W=13, POLY=13'h1B5F, INIT=0: 64 random frames with correct field bits. Required: crc_err=0 on every frame. Then flip one field bit. Required: crc_err=1.
